// File: rtl/jt12_timer_pkg.sv
// Shared constants and types for the FM Timer A / Timer B pair.
package jt12_timer_pkg;

  localparam int CNT_A_W  = 10;
  localparam int CNT_B_W  = 8;
  localparam int PRES_B_W = 4;

  localparam logic [CNT_A_W-1:0] CNT_A_MAX = 10'd1023;
  localparam logic [CNT_B_W-1:0] CNT_B_MAX = 8'd255;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/jt12_timer_cnt.sv
// One up-counting timer: load-edge detect, STOP/RUN state, optional
// prescaler (PRES_W = 0 removes it), counter with reload, overflow event.
// The overflow output is combinational; the parent registers it.
module jt12_timer_cnt
  import jt12_timer_pkg::*;
#(
  parameter int CNT_W  = 10,
  parameter int PRES_W = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             load_q, load_d;
  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_s, run_s, step_s, wrap_s;

  // Load edge against the registered copy; counting needs RUN with load still high.
  always_comb begin
    load_d = load;
    edge_s = load & ~load_q;
    run_s  = (state_q == ST_RUN) & load & ~edge_s;
    wrap_s = run_s & step_s & (cnt_q == CNT_MAX);
    ovf    = wrap_s;
  end

  // STOP/RUN next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (edge_s) state_d = ST_RUN;
        else        state_d = ST_STOP;
      end
      ST_RUN: begin
        if (!load) state_d = ST_STOP;
        else       state_d = ST_RUN;
      end
      default: state_d = ST_STOP;
    endcase
  end

  // Counter: a load edge wins over any coincident tick; reload on wrap.
  always_comb begin
    if (edge_s)              cnt_d = value;
    else if (wrap_s)         cnt_d = value;
    else if (run_s & step_s) cnt_d = cnt_q + CNT_ONE;
    else                     cnt_d = cnt_q;
  end

  generate
    if (PRES_W > 0) begin : g_pres
      localparam logic [PRES_W-1:0] PRES_ONE = {{(PRES_W-1){1'b0}}, 1'b1};
      logic [PRES_W-1:0] pres_q, pres_d;

      // Prescaler restarts on load and advances on every counted tick.
      always_comb begin
        if (edge_s)            pres_d = {PRES_W{1'b0}};
        else if (run_s & tick) pres_d = pres_q + PRES_ONE;
        else                   pres_d = pres_q;
      end

      assign step_s = tick & (pres_q == {PRES_W{1'b1}});

      // Prescaler register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pres_q <= {PRES_W{1'b0}};
        else        pres_q <= pres_d;
      end
    end else begin : g_nopres
      assign step_s = tick;
    end
  endgenerate

  // State, load copy and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q  <= 1'b0;
      state_q <= ST_STOP;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      load_q  <= load_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/jt12_timer_ab.sv
// FM Timer A (10-bit) and Timer B (8-bit, /16 prescaled) with overflow
// flags, active-low IRQ and a one-cycle Timer A overflow pulse for CSM.
module jt12_timer_ab #(
  parameter int CNT_A_W = jt12_timer_pkg::CNT_A_W,
  parameter int CNT_B_W = jt12_timer_pkg::CNT_B_W,
  parameter int PRES_B  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [CNT_A_W-1:0] value_a,
  input  logic [CNT_B_W-1:0] value_b,
  input  logic               load_a,
  input  logic               load_b,
  input  logic               en_a,
  input  logic               en_b,
  input  logic               clr_a,
  input  logic               clr_b,
  output logic               flag_a,
  output logic               flag_b,
  output logic               irq_n,
  output logic               ovf_a
);

  localparam int PRES_W_B = $clog2(PRES_B);

  logic ovf_a_s, ovf_b_s;
  logic flag_a_q, flag_a_d, flag_b_q, flag_b_d;
  logic ovf_a_q, ovf_a_d, irq_n_q, irq_n_d;

  jt12_timer_cnt #(.CNT_W(CNT_A_W), .PRES_W(0)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .load  (load_a),
    .value (value_a),
    .ovf   (ovf_a_s)
  );

  jt12_timer_cnt #(.CNT_W(CNT_B_W), .PRES_W(PRES_W_B)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .load  (load_b),
    .value (value_b),
    .ovf   (ovf_b_s)
  );

  // Flag set beats clear; IRQ follows the registered flags one cycle later.
  always_comb begin
    if (ovf_a_s & en_a) flag_a_d = 1'b1;
    else if (clr_a)     flag_a_d = 1'b0;
    else                flag_a_d = flag_a_q;
    if (ovf_b_s & en_b) flag_b_d = 1'b1;
    else if (clr_b)     flag_b_d = 1'b0;
    else                flag_b_d = flag_b_q;
    ovf_a_d = ovf_a_s;
    irq_n_d = ~(flag_a_q | flag_b_q);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
      ovf_a_q  <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
      ovf_a_q  <= ovf_a_d;
      irq_n_q  <= irq_n_d;
    end
  end

  assign flag_a = flag_a_q;
  assign flag_b = flag_b_q;
  assign ovf_a  = ovf_a_q;
  assign irq_n  = irq_n_q;

endmodule

// File: tb/tb_jt12_timer_ab.sv
// Self-checking bench for jt12_timer_ab: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_jt12_timer_ab;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] value_a = 10'd0;
  logic [7:0] value_b = 8'd0;
  logic       load_a = 1'b0, load_b = 1'b0;
  logic       en_a = 1'b0, en_b = 1'b0;
  logic       clr_a = 1'b0, clr_b = 1'b0;
  logic       flag_a, flag_b, irq_n, ovf_a;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  int m_cnt_a, m_cnt_b, m_pres;
  bit m_run_a, m_run_b, m_pl_a, m_pl_b;
  bit m_flag_a, m_flag_b, m_ovf_a, m_irq_n;

  jt12_timer_ab dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .value_a(value_a), .value_b(value_b),
    .load_a(load_a), .load_b(load_b),
    .en_a(en_a), .en_b(en_b), .clr_a(clr_a), .clr_b(clr_b),
    .flag_a(flag_a), .flag_b(flag_b), .irq_n(irq_n), .ovf_a(ovf_a)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_cnt_a = 0; m_cnt_b = 0; m_pres = 0;
    m_run_a = 0; m_run_b = 0; m_pl_a = 0; m_pl_b = 0;
    m_flag_a = 0; m_flag_b = 0; m_ovf_a = 0; m_irq_n = 1;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit ovf_a_ev, ovf_b_ev;
    ovf_a_ev = 0; ovf_b_ev = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (load_a && !m_pl_a) begin
        m_cnt_a = value_a; m_run_a = 1;
      end else if (!load_a) begin
        m_run_a = 0;
      end else if (m_run_a && tick) begin
        if (m_cnt_a == 1023) begin m_cnt_a = value_a; ovf_a_ev = 1; end
        else m_cnt_a = m_cnt_a + 1;
      end
      if (load_b && !m_pl_b) begin
        m_cnt_b = value_b; m_pres = 0; m_run_b = 1;
      end else if (!load_b) begin
        m_run_b = 0;
      end else if (m_run_b && tick) begin
        if (m_pres == 15) begin
          if (m_cnt_b == 255) begin m_cnt_b = value_b; ovf_b_ev = 1; end
          else m_cnt_b = m_cnt_b + 1;
        end
        m_pres = (m_pres + 1) % 16;
      end
      m_irq_n = !(m_flag_a || m_flag_b);
      if (ovf_a_ev && en_a) m_flag_a = 1; else if (clr_a) m_flag_a = 0;
      if (ovf_b_ev && en_b) m_flag_b = 1; else if (clr_b) m_flag_b = 0;
      m_ovf_a = ovf_a_ev;
      m_pl_a = load_a; m_pl_b = load_b;
    end
  endtask

  task automatic check_all();
    chk("flag_a", int'(flag_a), int'(m_flag_a));
    chk("flag_b", int'(flag_b), int'(m_flag_b));
    chk("irq_n",  int'(irq_n),  int'(m_irq_n));
    chk("ovf_a",  int'(ovf_a),  int'(m_ovf_a));
    chk("cnt_a",  int'(dut.u_cnt_a.cnt_q), m_cnt_a);
    chk("cnt_b",  int'(dut.u_cnt_b.cnt_q), m_cnt_b);
  endtask

  // One clock: inputs are applied at a falling edge, checked at the next.
  task automatic cyc();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  initial begin
    model_reset();
    load_a = 1'b1; value_a = 10'd100;
    @(negedge clk);
    check_all();
    // reset held with load_a high and ticks toggling
    for (int i = 0; i < 6; i++) begin
      tick = i[0];
      cyc();
    end
    tick = 1'b0;
    chk("rst_irq_n", int'(irq_n), 1);
    chk("rst_cnt_a", int'(dut.u_cnt_a.cnt_q), 0);
    rst_n = 1'b1;
    cyc();
    chk("rel_load_a", int'(dut.u_cnt_a.cnt_q), 100);

    // Timer A: 1020 overflows on the 4th tick
    load_a = 1'b0; cyc();
    value_a = 10'd1020; en_a = 1'b1; load_a = 1'b1; cyc();
    ticks(3);
    chk("a_no_flag_3", int'(flag_a), 0);
    ticks(1);
    chk("a_flag", int'(flag_a), 1);
    chk("a_ovf", int'(ovf_a), 1);
    chk("a_reload", int'(dut.u_cnt_a.cnt_q), 1020);
    cyc();
    chk("a_ovf_1cyc", int'(ovf_a), 0);
    chk("a_irq_n", int'(irq_n), 0);

    // stop / restart
    load_a = 1'b0; cyc();
    value_a = 10'd990; load_a = 1'b1; cyc();
    ticks(10);
    chk("a_at_1000", int'(dut.u_cnt_a.cnt_q), 1000);
    load_a = 1'b0; cyc();
    ticks(10);
    chk("a_hold", int'(dut.u_cnt_a.cnt_q), 1000);
    value_a = 10'd5; load_a = 1'b1; tick = 1'b1; cyc(); tick = 1'b0;
    chk("a_load_tick", int'(dut.u_cnt_a.cnt_q), 5);
    ticks(1);
    chk("a_after_load", int'(dut.u_cnt_a.cnt_q), 6);

    // flag control
    clr_a = 1'b1; cyc(); clr_a = 1'b0;
    chk("a_clr", int'(flag_a), 0);
    en_a = 1'b0; load_a = 1'b0; cyc();
    value_a = 10'd1022; load_a = 1'b1; cyc();
    ticks(2);
    chk("a_en0_ovf", int'(ovf_a), 1);
    chk("a_en0_flag", int'(flag_a), 0);
    en_a = 1'b1;
    ticks(1);
    tick = 1'b1; clr_a = 1'b1; cyc(); tick = 1'b0; clr_a = 1'b0;
    chk("a_set_wins", int'(flag_a), 1);
    cyc();
    clr_a = 1'b1; cyc(); clr_a = 1'b0;
    chk("a_clr_m1", int'(flag_a), 0);
    cyc();
    chk("a_irq_m2", int'(irq_n), 1);

    // Timer B: 254 overflows on the 32nd tick
    load_a = 1'b0; en_b = 1'b1; value_b = 8'd254; load_b = 1'b1; cyc();
    ticks(31);
    chk("b_no_flag_31", int'(flag_b), 0);
    ticks(1);
    chk("b_flag_32", int'(flag_b), 1);
    chk("b_no_ovf_a", int'(ovf_a), 0);
    chk("b_reload", int'(dut.u_cnt_b.cnt_q), 254);

    // async reset between edges while flag_b is set
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_flag_b", int'(flag_b), 0);
    chk("async_irq_n", int'(irq_n), 1);
    chk("async_cnt_b", int'(dut.u_cnt_b.cnt_q), 0);
    model_reset();
    @(negedge clk);
    check_all();
    load_b = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 39) == 0) load_a = ~load_a;
      if ($urandom_range(0, 39) == 0) load_b = ~load_b;
      if ($urandom_range(0, 15) == 0) value_a = 10'(1024 - $urandom_range(1, 12));
      if ($urandom_range(0, 15) == 0) value_b = 8'(255 - $urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) en_a = ~en_a;
      if ($urandom_range(0, 19) == 0) en_b = ~en_b;
      clr_a = ($urandom_range(0, 11) == 0);
      clr_b = ($urandom_range(0, 11) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      cyc();
    end
    rst_n = 1'b1; tick = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jt12_timer_ab.md
# jt12_timer_ab

FM timer pair (Timer A, 10-bit; Timer B, 8-bit with /16 prescaler) for the OPN core. Sits directly downstream of the clock-enable divider: it consumes the per-sample tick derived from the divider's FM clock enable and produces overflow flags, the IRQ line and a CSM key-on pulse for the register/channel logic.

## Interface
- `CNT_A_W`, default 10: Timer A counter width.
- `CNT_B_W`, default 8: Timer B counter width.
- `PRES_B`, default 16: Timer B prescale ratio, in ticks.
- `clk` in 1: system clock, the same clock the divider runs on.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle pulse, once per FM sample, i.e. the divider `clk_en` qualified by slot zero.
- `value_a` in 10: Timer A reload value.
- `value_b` in 8: Timer B reload value.
- `load_a`, `load_b` in 1: timer run bits, level signals.
- `en_a`, `en_b` in 1: flag-set enables.
- `clr_a`, `clr_b` in 1: one-cycle flag-clear strobes.
- `flag_a`, `flag_b` out 1: overflow flags, registered.
- `irq_n` out 1: active-low interrupt, `~(flag_a | flag_b)`, registered.
- `ovf_a` out 1: one-cycle Timer A overflow pulse, used for CSM key-on.

## Operation
- Each timer has two states, STOP and RUN.
  - STOP→RUN on a rising edge of `load_x`, detected against a registered copy.
  - RUN→STOP when `load_x` is low. In STOP the counter holds its value.
- Load edge:
  - Counter is set to `value_x`.
  - Timer B prescaler is set to 0.
  - Takes effect in the same cycle the edge is seen. A coincident `tick` is ignored for that timer.
- Timer A in RUN, on `tick`:
  - If cnt==1023: cnt←`value_a`, overflow event.
  - Otherwise cnt←cnt+1.
- Timer B in RUN, on `tick`:
  - Prescaler increments, wrapping 15→0.
  - Only on the tick where the prescaler is 15 does the counter step. If cnt==255: cnt←`value_b`, overflow event; otherwise cnt+1.
- Changing `value_x` while in RUN affects only the next reload.
- Overflow event on timer x:
  - `flag_x` sets if `en_x`=1.
  - `ovf_a` pulses on every Timer A overflow, independent of `en_a`.
- `clr_x` clears `flag_x`. If an overflow set and a `clr_x` land in the same cycle, set wins.
- Clearing `en_x` does not clear an already-set flag.
- All arithmetic is unsigned and wraps within width. There are no other counts.

## Timing
- Reset values:
  - Counters 0, prescaler 0, state STOP, registered load copies 0.
  - `flag_a`=`flag_b`=0, `ovf_a`=0, `irq_n`=1.
- Overflow latency: the tick cycle at cnt==max is cycle N.
  - Cycle N+1: `flag_x` and `ovf_a` high, counter already reloaded.
  - Cycle N+2: `irq_n` low.
- `ovf_a` is high for exactly one clk cycle.
- `clr_x` at cycle M: flag low at M+1, `irq_n` high at M+2 if the other flag is 0.
- Period, with the load edge in a non-tick cycle:
  - Timer A: overflow on the (1024−`value_a`)-th tick after load.
  - Timer B: overflow on the 16·(256−`value_b`)-th tick after load.
- `rst_n` is asserted asynchronously and takes effect immediately, including mid-count. Deassertion is synchronised externally. After release both timers stay in STOP until a fresh `load_x` rising edge; a `load_x` already high at release counts as an edge, because the registered copy resets to 0.
- No handshake. `tick` may be present on any cycle, including back-to-back cycles in fast simulation, and each tick is counted.

## Structure
- Package `jt12_timer_pkg` holds:
  - width constants `CNT_A_W`, `CNT_B_W`, `PRES_B_W`=4;
  - max values 1023 and 255;
  - state enum `{ST_STOP, ST_RUN}`.
- Sub-module `jt12_timer_cnt`, parameterised by counter width and prescaler width (0 = no prescaler). It contains the load-edge detect, state, prescaler, counter, reload and overflow pulse.
- Top instantiates it twice and adds the flag set/clear logic, `ovf_a` and the `irq_n` register.

## Test plan
- Reset check: hold `rst_n`=0 with `load_a`=1 and ticks toggling → counters 0, `irq_n`=1, flags 0. Release → Timer A loads on the first cycle.
- Timer A: `value_a`=1020, `en_a`=1, raise `load_a`, then 4 ticks → `flag_a`=1 and `ovf_a` pulse one cycle after the 4th tick. `irq_n`=0 one cycle later. Counter reads 1020.
- Timer B: `value_b`=254, `en_b`=1, raise `load_b`, then 31 ticks → no flag. 32nd tick → `flag_b`=1. `ovf_a` never pulses.
- Flag control:
  - With `en_a`=0, overflow → `ovf_a` pulses, `flag_a` stays 0.
  - Then `en_a`=1, overflow with `clr_a` in the same cycle → `flag_a`=1.
  - `clr_a` alone → flag 0, `irq_n` 1 two cycles later.
- Stop/restart: drop `load_a` mid-count at cnt=1000 → holds 1000 across 10 ticks. Raise `load_a` with `value_a`=5 coincident with a tick → cnt=5, no increment that cycle.
- Async reset mid-operation: assert `rst_n` between clock edges while `flag_b`=1 → `flag_b`, `irq_n` and counters reset without waiting for a clock edge.
